// File: rtl/sap_cpu_core_if.sv
// Host-side bus of sap_cpu_core: program load, run request, output register and status.
interface sap_cpu_core_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              run;
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [DATA_W-1:0] prog_data;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              busy;
    logic              halted;
    logic [ADDR_W-1:0] pc_dbg;
    logic              carry;
    logic              zero;

    modport master (output run, prog_we, prog_addr, prog_data,
                    input  out_data, out_valid, busy, halted, pc_dbg, carry, zero);
    modport slave  (input  run, prog_we, prog_addr, prog_data,
                    output out_data, out_valid, busy, halted, pc_dbg, carry, zero);
endinterface

// File: rtl/sap_cpu_core.sv
// Parametrised accumulator CPU core: PC/IR/A/flags, unified RAM, FETCH/EXEC sequencer.
// Optional single-step support under `define SAP_CPU_SINGLE_STEP_EN (step_mode/step/paused, PAUSE state).
//
// state | meaning
// IDLE  | after reset, waiting for run
// FETCH | IR <= mem[PC], PC <= PC+1
// EXEC  | execute IR; next FETCH, HALT on HLT, PAUSE when single-stepping
// HALT  | stopped by HLT; run resumes at the PC after HLT
// PAUSE | single-step only: waiting for step
module sap_cpu_core #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic clk,
    input  logic rst,
`ifdef SAP_CPU_SINGLE_STEP_EN
    input  logic step_mode,
    input  logic step,
    output logic paused,
`endif
    sap_cpu_core_if.slave bus
);
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

`ifdef SAP_CPU_SINGLE_STEP_EN
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT, S_PAUSE} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT} state_t;
`endif

    state_t            state, state_nxt;
    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] ir;
    logic [DATA_W-1:0] acc;
    logic              carry_q, zero_q;
    logic [DATA_W-1:0] out_q;
    logic              out_valid_q;
    logic              busy_c, halted_c, host_we, sta_we;

    logic [3:0]        opcode;
    logic [ADDR_W-1:0] operand;
    logic [DATA_W-1:0] instr_word, oper_word, diff;
    logic [DATA_W:0]   sum;
    logic              unused_ir_bits;

    assign opcode         = ir[DATA_W-1 -: 4];
    assign operand        = ir[ADDR_W-1:0];
    assign unused_ir_bits = ^ir;
    assign instr_word     = mem[pc];
    assign oper_word      = mem[operand];
    assign sum            = {1'b0, acc} + {1'b0, oper_word};
    assign diff           = acc - oper_word;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_HALT: if (bus.run) state_nxt = S_FETCH;
            S_FETCH:        state_nxt = S_EXEC;
            S_EXEC: begin
                if (opcode == OP_HLT)  state_nxt = S_HALT;
`ifdef SAP_CPU_SINGLE_STEP_EN
                else if (step_mode)    state_nxt = S_PAUSE;
`endif
                else                   state_nxt = S_FETCH;
            end
`ifdef SAP_CPU_SINGLE_STEP_EN
            S_PAUSE:        if (step) state_nxt = S_FETCH;
`endif
            default:        state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy_c   = (state == S_FETCH) || (state == S_EXEC);
        halted_c = (state == S_HALT);
        host_we  = bus.prog_we && ((state == S_IDLE) || (state == S_HALT));
        sta_we   = (state == S_EXEC) && (opcode == OP_STA);
`ifdef SAP_CPU_SINGLE_STEP_EN
        paused   = (state == S_PAUSE);
`endif
    end

    // RAM is not reset; a write is suppressed on any edge where rst is high.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (host_we)     mem[bus.prog_addr] <= bus.prog_data;
            else if (sta_we) mem[operand]       <= acc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= '0;
            ir          <= '0;
            acc         <= '0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            if (state == S_FETCH) begin
                ir <= instr_word;
                pc <= pc + ADDR_W'(1);
            end
            if (state == S_EXEC) begin
                case (opcode)
                    OP_LDA: acc <= oper_word;
                    OP_ADD: begin
                        {carry_q, acc} <= sum;
                        zero_q         <= (sum[DATA_W-1:0] == '0);
                    end
                    OP_SUB: begin
                        acc     <= diff;
                        carry_q <= (acc >= oper_word);
                        zero_q  <= (diff == '0);
                    end
                    OP_LDI: acc <= DATA_W'(operand);
                    OP_JMP: pc <= operand;
                    OP_JC:  if (carry_q) pc <= operand;
                    OP_JZ:  if (zero_q)  pc <= operand;
                    OP_OUT: begin
                        out_q       <= acc;
                        out_valid_q <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.out_data  = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_c;
    assign bus.halted    = halted_c;
    assign bus.pc_dbg    = pc;
    assign bus.carry     = carry_q;
    assign bus.zero      = zero_q;
endmodule

// File: tb/tb_sap_cpu_core.sv
// Scoreboard bench for sap_cpu_core: expected OUT/HALT events are queued by the stimulus
// and popped by per-core monitors; an 8/4 core and a 12/8 core share clk and rst.
module tb_sap_cpu_core;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sap_cpu_core_if #(.DATA_W(8),  .ADDR_W(4)) bus0();
    sap_cpu_core_if #(.DATA_W(12), .ADDR_W(8)) bus1();

`ifdef SAP_CPU_SINGLE_STEP_EN
    logic step_mode0 = 1'b0, step0 = 1'b0, paused0;
    logic step_mode1 = 1'b0, step1 = 1'b0, paused1;
`endif

    sap_cpu_core #(.DATA_W(8), .ADDR_W(4)) dut0 (
        .clk(clk), .rst(rst),
`ifdef SAP_CPU_SINGLE_STEP_EN
        .step_mode(step_mode0), .step(step0), .paused(paused0),
`endif
        .bus(bus0)
    );

    sap_cpu_core #(.DATA_W(12), .ADDR_W(8)) dut1 (
        .clk(clk), .rst(rst),
`ifdef SAP_CPU_SINGLE_STEP_EN
        .step_mode(step_mode1), .step(step1), .paused(paused1),
`endif
        .bus(bus1)
    );

    typedef struct packed {
        logic        is_halt;
        logic [15:0] data;
        logic [7:0]  pc;
        logic        c;
        logic        z;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   checks   = 0;
    int   failures = 0;
    logic halted0_d = 1'b0;
    logic halted1_d = 1'b0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endfunction

    function automatic exp_t mk_out(input logic [15:0] d);
        exp_t e;
        e      = '0;
        e.data = d;
        return e;
    endfunction

    function automatic exp_t mk_halt(input logic [7:0] pc, input logic c, input logic z);
        exp_t e;
        e         = '0;
        e.is_halt = 1'b1;
        e.pc      = pc;
        e.c       = c;
        e.z       = z;
        return e;
    endfunction

    function automatic void score(input int which, input logic is_halt, input logic [15:0] d,
                                  input logic [7:0] pc, input logic c, input logic z);
        exp_t e;
        logic have;
        if (which == 0) have = (q0.size() > 0) && (q0[0].is_halt == is_halt);
        else            have = (q1.size() > 0) && (q1[0].is_halt == is_halt);
        check($sformatf("dut%0d_%s_event_expected", which, is_halt ? "halt" : "out"),
              32'(have), 32'd1);
        if (!have) return;
        e = (which == 0) ? q0.pop_front() : q1.pop_front();
        if (is_halt) begin
            check($sformatf("dut%0d_halt_pc", which),    32'(pc), 32'(e.pc));
            check($sformatf("dut%0d_halt_carry", which), 32'(c),  32'(e.c));
            check($sformatf("dut%0d_halt_zero", which),  32'(z),  32'(e.z));
        end else begin
            check($sformatf("dut%0d_out_data", which),   32'(d),  32'(e.data));
        end
    endfunction

    always @(negedge clk) begin
        if (bus0.out_valid)
            score(0, 1'b0, 16'(bus0.out_data), 8'(bus0.pc_dbg), bus0.carry, bus0.zero);
        if (bus0.halted && !halted0_d)
            score(0, 1'b1, 16'(bus0.out_data), 8'(bus0.pc_dbg), bus0.carry, bus0.zero);
        halted0_d = bus0.halted;
    end

    always @(negedge clk) begin
        if (bus1.out_valid)
            score(1, 1'b0, 16'(bus1.out_data), 8'(bus1.pc_dbg), bus1.carry, bus1.zero);
        if (bus1.halted && !halted1_d)
            score(1, 1'b1, 16'(bus1.out_data), 8'(bus1.pc_dbg), bus1.carry, bus1.zero);
        halted1_d = bus1.halted;
    end

    // All driving tasks start and end just after a falling edge.
    task automatic load0(input int a, input logic [7:0] d);
        bus0.prog_we = 1'b1; bus0.prog_addr = 4'(a); bus0.prog_data = d;
        @(negedge clk);
        bus0.prog_we = 1'b0;
    endtask

    task automatic load1(input int a, input logic [11:0] d);
        bus1.prog_we = 1'b1; bus1.prog_addr = 8'(a); bus1.prog_data = d;
        @(negedge clk);
        bus1.prog_we = 1'b0;
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_reset0(input string tag);
        check({tag, "_out_data"},  32'(bus0.out_data),  32'd0);
        check({tag, "_out_valid"}, 32'(bus0.out_valid), 32'd0);
        check({tag, "_busy"},      32'(bus0.busy),      32'd0);
        check({tag, "_halted"},    32'(bus0.halted),    32'd0);
        check({tag, "_pc"},        32'(bus0.pc_dbg),    32'd0);
        check({tag, "_carry"},     32'(bus0.carry),     32'd0);
        check({tag, "_zero"},      32'(bus0.zero),      32'd0);
    endtask

    // Pulse run; n counts rising edges after the run edge until halted. With busy_we
    // the host keeps writing OUT into mem[3] for the first six (busy) cycles.
    task automatic run0(input int budget, input bit busy_we, output int n);
        bus0.run = 1'b1;
        @(posedge clk); #1;
        bus0.run     = 1'b0;
        bus0.prog_we = busy_we;
        if (busy_we) begin bus0.prog_addr = 4'd3; bus0.prog_data = 8'hE0; end
        n = 0;
        while (!bus0.halted && n < budget) begin
            @(posedge clk); #1;
            n++;
            if (n == 6) bus0.prog_we = 1'b0;
        end
        bus0.prog_we = 1'b0;
        check("dut0_halt_reached", 32'(bus0.halted), 32'd1);
        @(negedge clk);
    endtask

    task automatic run1(input int budget, output int n);
        bus1.run = 1'b1;
        @(posedge clk); #1;
        bus1.run = 1'b0;
        n = 0;
        while (!bus1.halted && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check("dut1_halt_reached", 32'(bus1.halted), 32'd1);
        @(negedge clk);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        bus0.run = 1'b0; bus0.prog_we = 1'b0; bus0.prog_addr = '0; bus0.prog_data = '0;
        bus1.run = 1'b0; bus1.prog_we = 1'b0; bus1.prog_addr = '0; bus1.prog_data = '0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check_reset0("reset");
        for (int i = 0; i < 16; i++) load0(i, 8'h00);

        // LDA 14; ADD 15; OUT; HLT with 5 + 7
        load0(0, 8'h1E); load0(1, 8'h2F); load0(2, 8'hE0); load0(3, 8'hF0);
        load0(14, 8'h05); load0(15, 8'h07);
        q0.push_back(mk_out(16'h0C));
        q0.push_back(mk_halt(8'd4, 1'b0, 1'b0));
        run0(40, 1'b0, n);
        check("add_out_cycles_to_halt", 32'(n), 32'd8);

        // LDI 3; SUB 15 (=5) borrows; JZ 9 and JC 9 both fall through
        do_reset();
        load0(0, 8'h53); load0(1, 8'h3F); load0(2, 8'h89); load0(3, 8'h79);
        load0(4, 8'hE0); load0(5, 8'hF0); load0(15, 8'h05);
        q0.push_back(mk_out(16'hFE));
        q0.push_back(mk_halt(8'd6, 1'b0, 1'b0));
        run0(40, 1'b0, n);

        // LDI 7; SUB 15 (=7): no borrow, zero result
        do_reset();
        load0(0, 8'h57); load0(1, 8'h3F); load0(2, 8'hE0); load0(3, 8'hF0); load0(15, 8'h07);
        q0.push_back(mk_out(16'h00));
        q0.push_back(mk_halt(8'd4, 1'b1, 1'b1));
        run0(40, 1'b0, n);

        // 0xFF + 0x01 wraps to zero; JZ 9 taken to OUT at 9, HLT at 10
        do_reset();
        load0(0, 8'h1E); load0(1, 8'h2F); load0(2, 8'h89); load0(3, 8'hF0);
        load0(9, 8'hE0); load0(10, 8'hF0); load0(14, 8'hFF); load0(15, 8'h01);
        q0.push_back(mk_out(16'h00));
        q0.push_back(mk_halt(8'd11, 1'b1, 1'b1));
        run0(40, 1'b0, n);

        // same sequence with JC 9
        do_reset();
        load0(2, 8'h79);
        q0.push_back(mk_out(16'h00));
        q0.push_back(mk_halt(8'd11, 1'b1, 1'b1));
        run0(40, 1'b0, n);

        // LDA 13 (=OUT opcode); STA 2 turns the next instruction into OUT; host writes while busy
        do_reset();
        load0(0, 8'h1D); load0(1, 8'h42); load0(2, 8'hF0); load0(3, 8'hF0); load0(13, 8'hE0);
        q0.push_back(mk_out(16'hE0));
        q0.push_back(mk_halt(8'd4, 1'b0, 1'b0));
        run0(40, 1'b1, n);

        // reset during EXEC of STA 12 aborts it; a host write with rst high is dropped too
        do_reset();
        load0(0, 8'h59); load0(1, 8'h4C); load0(2, 8'hF0); load0(12, 8'h33);
        bus0.run = 1'b1;
        @(posedge clk); #1 bus0.run = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1 check_reset0("abort");
        bus0.prog_we = 1'b1; bus0.prog_addr = 4'd12; bus0.prog_data = 8'h77;
        @(posedge clk); #1 bus0.prog_we = 1'b0;
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        load0(0, 8'h1C); load0(1, 8'hE0); load0(2, 8'hF0);
        q0.push_back(mk_out(16'h33));
        q0.push_back(mk_halt(8'd3, 1'b0, 1'b0));
        run0(40, 1'b0, n);

        // halt then resume; the resume run also rewrites mem[3] to LDI 7 in the same cycle
        do_reset();
        load0(0, 8'h54); load0(1, 8'hE0); load0(2, 8'hF0);
        load0(3, 8'h56); load0(4, 8'hE0); load0(5, 8'hF0);
        q0.push_back(mk_out(16'h04));
        q0.push_back(mk_halt(8'd3, 1'b0, 1'b0));
        run0(40, 1'b0, n);
        bus0.prog_we = 1'b1; bus0.prog_addr = 4'd3; bus0.prog_data = 8'h57;
        q0.push_back(mk_out(16'h07));
        q0.push_back(mk_halt(8'd6, 1'b0, 1'b0));
        run0(40, 1'b0, n);

        // PC wrap, 4-bit address: HLT at 0, NOPs, LDI 10 at 14, OUT at 15
        do_reset();
        load0(0, 8'hF0);
        for (int i = 1; i < 14; i++) load0(i, 8'h00);
        load0(14, 8'h5A); load0(15, 8'hE0);
        q0.push_back(mk_halt(8'd1, 1'b0, 1'b0));
        run0(40, 1'b0, n);
        check("wrap0_first_cycles", 32'(n), 32'd2);
        q0.push_back(mk_out(16'h0A));
        q0.push_back(mk_halt(8'd1, 1'b0, 1'b0));
        run0(80, 1'b0, n);
        check("wrap0_cycles", 32'(n), 32'd32);

        // PC wrap, 12-bit data / 8-bit address: HLT at 0, LDI 0xAB at 254, OUT at 255
        load1(0, 12'hF00);
        for (int i = 1; i < 254; i++) load1(i, 12'h000);
        load1(254, 12'h5AB); load1(255, 12'hE00);
        q1.push_back(mk_halt(8'd1, 1'b0, 1'b0));
        run1(40, n);
        q1.push_back(mk_out(16'h0AB));
        q1.push_back(mk_halt(8'd1, 1'b0, 1'b0));
        run1(600, n);
        check("wrap1_cycles", 32'(n), 32'd512);

        repeat (3) @(negedge clk);
        check("dut0_queue_drained", 32'(q0.size()), 32'd0);
        check("dut1_queue_drained", 32'(q1.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sap_cpu_core.md
Name: sap_cpu_core

Overview:
- Parametrised, self-contained accumulator CPU core. Successor to the fixed 8-bit, 4-bit-address SAP-style top level.
- Holds PC, IR, accumulator, carry/zero flags, unified program/data RAM and a FETCH/EXEC sequencer in one block.
- Generalised in data width and address width. Adds conditional jumps, store, immediate load, halt/resume and host program loading.
- Sits under the chip top; host drives program load and run, and observes output and status.

Parameters:
- DATA_W, 8: data, accumulator and RAM word width. Must be at least ADDR_W+4.
- ADDR_W, 4: PC and RAM address width. RAM depth is 2**ADDR_W words.

Ports:
- clk, input, 1: clock, rising edge.
- rst, input, 1: reset, asynchronous, active-high.
- run, input, 1: start/resume request, sampled in IDLE or HALT.
- prog_we, input, 1: host RAM write strobe.
- prog_addr, input, ADDR_W: host write address.
- prog_data, input, DATA_W: host write data.
- out_data, output, DATA_W: output register, loaded by OUT.
- out_valid, output, 1: one-cycle pulse when out_data is updated.
- busy, output, 1: high in FETCH or EXEC.
- halted, output, 1: high in HALT.
- pc_dbg, output, ADDR_W: current PC.
- carry, output, 1: carry flag.
- zero, output, 1: zero flag.

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to IDLE.
  - PC, IR, A, carry, zero, out_data and out_valid go to 0.
  - RAM contents are not reset.
- Instruction word: opcode = bits [DATA_W-1:DATA_W-4]; operand = bits [ADDR_W-1:0]. Any bits in between are ignored.
- States: IDLE, FETCH, EXEC, HALT.
  - IDLE or HALT with run=1 goes to FETCH on the next edge. PC is kept, so HALT resumes at the instruction after HLT.
  - FETCH (1 cycle): IR <= mem[PC]; PC <= PC+1. PC wraps from 2**ADDR_W-1 to 0.
  - EXEC (1 cycle): performs the opcode, then goes to FETCH. HLT goes to HALT instead.
  - Every instruction takes exactly 2 cycles.
- Opcodes (a = operand, k = operand zero-extended to DATA_W):
  - 0x0 NOP.
  - 0x1 LDA: A <= mem[a].
  - 0x2 ADD: {carry,A} <= A+mem[a]; zero <= (result==0).
  - 0x3 SUB: A <= A-mem[a]; carry <= (A >= mem[a]), i.e. no borrow; zero <= (result==0).
  - 0x4 STA: mem[a] <= A.
  - 0x5 LDI: A <= k.
  - 0x6 JMP: PC <= a.
  - 0x7 JC: PC <= a if carry.
  - 0x8 JZ: PC <= a if zero.
  - 0xE OUT: out_data <= A; out_valid high for the following cycle only.
  - 0xF HLT.
  - 0x9–0xD: execute as NOP.
- Flags change only on ADD and SUB. Conditional jumps use the flag values held before the EXEC edge.
- RAM read is combinational from the register array. Writes are synchronous.
- Host writes:
  - Accepted only in IDLE or HALT; ignored while busy.
  - prog_we and run in the same cycle: the write commits on that edge, so the first FETCH sees the new data.
- STA to the address of the next instruction: the next FETCH sees the stored value.
- Reset asserted mid-instruction aborts immediately. No RAM write occurs on the edge where rst is high.

Optional Feature:
- Macro SAP_CPU_SINGLE_STEP_EN.
- Defined:
  - Adds ports step_mode (input, 1), step (input, 1) and paused (output, 1).
  - Adds state PAUSE. With step_mode=1, EXEC goes to PAUSE instead of FETCH; paused=1 and busy=0 in PAUSE.
  - A step=1 sample in PAUSE goes to FETCH. HLT still goes to HALT.
  - With step_mode=0 the behaviour is identical to the undefined case.
- Undefined: no extra ports and no PAUSE state.

Test Plan:
- Add and output: load mem[0..3]=0x1E,0x2F,0xE0,0xF0 and mem[14]=0x05, mem[15]=0x07, then pulse run.
  - out_valid pulses once with out_data=0x0C.
  - halted=1 eight cycles after FETCH starts; pc_dbg=4.
- Subtract with borrow: LDI 3, SUB from a cell holding 0x05.
  - A=0xFE, carry=0, zero=0.
- Wrap to zero and branch: 0xFF+0x01.
  - A=0x00, carry=1, zero=1.
  - A following JZ 0x9 is taken (pc_dbg=9). The same sequence with JC is also taken.
- Store and self-modify: STA to the next instruction address, then run.
  - Fetched IR equals the stored A.
  - prog_we asserted while busy leaves RAM unchanged.
- Reset and resume:
  - Assert rst in EXEC of STA: no write; all outputs return to 0.
  - Separately, pulse run in HALT: execution resumes at the address after HLT.
- PC wrap: HLT placed at 0 and program filling to address 15 with ADDR_W=4.
  - PC wraps 15 to 0 and the core halts.
  - Repeat at DATA_W=12, ADDR_W=8.
